// File: rtl/alu_sequencer.sv
// Fetch/decode/execute controller that runs a program from instruction memory through an 8-bit ALU.
// Define ALU_SEQ_RETIRE_CNT_EN to add the 16-bit retired-instruction counter output.
module alu_sequencer #(
  parameter int         AW      = 8,
  parameter int         ALU_LAT = 1,
  parameter logic [5:0] HALT_OP = 6'h3F
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [15:0]   imem_data,
  output logic [5:0]    alu_opcode,
  output logic [7:0]    alu_in1,
  output logic [7:0]    alu_in2,
  input  logic [7:0]    alu_out,
  output logic [7:0]    acc_a,
  output logic [7:0]    acc_b,
  output logic          busy,
`ifdef ALU_SEQ_RETIRE_CNT_EN
  output logic [15:0]   retired,
`endif
  output logic          halted
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} state_e;

  localparam int            CW       = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0] LAT_LOAD = (ALU_LAT > 0) ? CW'(ALU_LAT - 1) : '0;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [15:0]   ir_q, ir_d;
  logic [7:0]    acc_a_q, acc_a_d;
  logic [7:0]    acc_b_q, acc_b_d;
  logic [5:0]    alu_opcode_q, alu_opcode_d;
  logic [7:0]    alu_in1_q, alu_in1_d;
  logic [7:0]    alu_in2_q, alu_in2_d;
  logic          imem_req_q, imem_req_d;
  logic          busy_q, busy_d;
  logic          halted_q, halted_d;
  logic [CW-1:0] lat_cnt_q, lat_cnt_d;
`ifdef ALU_SEQ_RETIRE_CNT_EN
  logic [15:0]   retired_q, retired_d;
`endif

  logic [5:0] ir_op;
  logic       ir_dst;
  logic       ir_imm;
  logic [7:0] ir_val;
  logic [7:0] dst_acc;
  logic [7:0] src_acc;

  assign {ir_op, ir_dst, ir_imm, ir_val} = ir_q;
  assign dst_acc = ir_dst ? acc_b_q : acc_a_q;
  assign src_acc = ir_dst ? acc_a_q : acc_b_q;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    acc_a_d      = acc_a_q;
    acc_b_d      = acc_b_q;
    alu_opcode_d = alu_opcode_q;
    alu_in1_d    = alu_in1_q;
    alu_in2_d    = alu_in2_q;
    imem_req_d   = imem_req_q;
    busy_d       = busy_q;
    halted_d     = halted_q;
    lat_cnt_d    = lat_cnt_q;
`ifdef ALU_SEQ_RETIRE_CNT_EN
    retired_d    = retired_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          pc_d       = '0;
          imem_req_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = FETCH;
`ifdef ALU_SEQ_RETIRE_CNT_EN
          retired_d  = '0;
`endif
        end
      end

      FETCH: begin
        // Request and address are registered, so they stay put until the ack edge.
        if (imem_ack) begin
          ir_d       = imem_data;
          pc_d       = pc_q + AW'(1);
          imem_req_d = 1'b0;
          state_d    = DECODE;
        end
      end

      DECODE: begin
        if (ir_op == HALT_OP) begin
          busy_d   = 1'b0;
          halted_d = 1'b1;
          state_d  = HALT;
        end else begin
          alu_opcode_d = ir_op;
          alu_in1_d    = dst_acc;
          alu_in2_d    = ir_imm ? ir_val : src_acc;
          lat_cnt_d    = LAT_LOAD;
          state_d      = (ALU_LAT > 0) ? EXEC : WB;
        end
      end

      EXEC: begin
        if (lat_cnt_q == '0) begin
          state_d = WB;
        end else begin
          lat_cnt_d = lat_cnt_q - CW'(1);
        end
      end

      WB: begin
        if (ir_dst) begin
          acc_b_d = alu_out;
        end else begin
          acc_a_d = alu_out;
        end
        imem_req_d = 1'b1;
        state_d    = FETCH;
`ifdef ALU_SEQ_RETIRE_CNT_EN
        retired_d  = retired_q + 16'd1;
`endif
      end

      HALT: begin
        // Restart keeps both accumulators so a program can continue from prior results.
        if (start) begin
          pc_d       = '0;
          halted_d   = 1'b0;
          busy_d     = 1'b1;
          imem_req_d = 1'b1;
          state_d    = FETCH;
`ifdef ALU_SEQ_RETIRE_CNT_EN
          retired_d  = '0;
`endif
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge value of its neighbours.
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      ir_q         <= '0;
      acc_a_q      <= '0;
      acc_b_q      <= '0;
      alu_opcode_q <= '0;
      alu_in1_q    <= '0;
      alu_in2_q    <= '0;
      imem_req_q   <= 1'b0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
      lat_cnt_q    <= '0;
`ifdef ALU_SEQ_RETIRE_CNT_EN
      retired_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      acc_a_q      <= acc_a_d;
      acc_b_q      <= acc_b_d;
      alu_opcode_q <= alu_opcode_d;
      alu_in1_q    <= alu_in1_d;
      alu_in2_q    <= alu_in2_d;
      imem_req_q   <= imem_req_d;
      busy_q       <= busy_d;
      halted_q     <= halted_d;
      lat_cnt_q    <= lat_cnt_d;
`ifdef ALU_SEQ_RETIRE_CNT_EN
      retired_q    <= retired_d;
`endif
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign alu_opcode = alu_opcode_q;
  assign alu_in1    = alu_in1_q;
  assign alu_in2    = alu_in2_q;
  assign acc_a      = acc_a_q;
  assign acc_b      = acc_b_q;
  assign busy       = busy_q;
  assign halted     = halted_q;
`ifdef ALU_SEQ_RETIRE_CNT_EN
  assign retired    = retired_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: two instances (AW=8/ALU_LAT=1 and AW=2/ALU_LAT=2),
// a behavioural memory + ALU, and a program-level reference model.
module tb_alu_sequencer;
  localparam logic [5:0] HALT_OP = 6'h3F;
  localparam int LAT0 = 1;
  localparam int LAT1 = 2;
  localparam logic [5:0] OP_ADD = 6'd0, OP_SUB = 6'd1, OP_AND = 6'd2,
                         OP_OR = 6'd3, OP_XOR = 6'd4, OP_MOV = 6'd5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        start [2];
  logic        req [2];
  logic        ack [2];
  logic [15:0] data [2];
  logic [5:0]  op [2];
  logic [7:0]  in1 [2];
  logic [7:0]  in2 [2];
  logic [7:0]  aout [2];
  logic [7:0]  acca [2];
  logic [7:0]  accb [2];
  logic        busy [2];
  logic        halted [2];
  logic [7:0]  addr0;
  logic [1:0]  addr1;
  int          addr_i [2];
`ifdef ALU_SEQ_RETIRE_CNT_EN
  logic [15:0] ret [2];
`endif

  always_comb begin
    addr_i[0] = int'(addr0);
    addr_i[1] = int'(addr1);
  end

  alu_sequencer #(.AW(8), .ALU_LAT(LAT0), .HALT_OP(HALT_OP)) u_dut0 (
    .clk(clk), .reset(reset), .start(start[0]),
    .imem_req(req[0]), .imem_addr(addr0), .imem_ack(ack[0]), .imem_data(data[0]),
    .alu_opcode(op[0]), .alu_in1(in1[0]), .alu_in2(in2[0]), .alu_out(aout[0]),
    .acc_a(acca[0]), .acc_b(accb[0]), .busy(busy[0]),
`ifdef ALU_SEQ_RETIRE_CNT_EN
    .retired(ret[0]),
`endif
    .halted(halted[0]));

  alu_sequencer #(.AW(2), .ALU_LAT(LAT1), .HALT_OP(HALT_OP)) u_dut1 (
    .clk(clk), .reset(reset), .start(start[1]),
    .imem_req(req[1]), .imem_addr(addr1), .imem_ack(ack[1]), .imem_data(data[1]),
    .alu_opcode(op[1]), .alu_in1(in1[1]), .alu_in2(in2[1]), .alu_out(aout[1]),
    .acc_a(acca[1]), .acc_b(accb[1]), .busy(busy[1]),
`ifdef ALU_SEQ_RETIRE_CNT_EN
    .retired(ret[1]),
`endif
    .halted(halted[1]));

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  function automatic logic [7:0] alu_f(input logic [5:0] o, input logic [7:0] x, input logic [7:0] y);
    case (o)
      OP_ADD:  return x + y;
      OP_SUB:  return x - y;
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_XOR:  return x ^ y;
      OP_MOV:  return y;
      default: return (x + 8'(o)) ^ y;
    endcase
  endfunction

  function automatic logic [15:0] ins(input logic [5:0] o, input logic dst, input logic imm, input logic [7:0] v);
    return {o, dst, imm, v};
  endfunction

  function automatic logic [15:0] rand_ins();
    logic [5:0] o;
    o = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 62)) : 6'($urandom_range(0, 5));
    return {o, 1'($urandom), 1'($urandom), 8'($urandom)};
  endfunction

  // Instruction memory with programmable ack delay; junk data and stray acks when not requested.
  logic [15:0] mem [2][256];
  int fixed_wait [2];
  int tgt [2];
  int cnt [2];
  int wait_q [$];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (req[d]) begin
        if (tgt[d] < 0) begin
          tgt[d] = (fixed_wait[d] >= 0) ? fixed_wait[d] : int'($urandom_range(0, 3));
          cnt[d] = 0;
        end
        if (cnt[d] == tgt[d]) begin
          ack[d]  = 1'b1;
          data[d] = mem[d][addr_i[d]];
          wait_q.push_back(tgt[d]);
          tgt[d]  = -1;
        end else begin
          ack[d]  = 1'b0;
          data[d] = 16'($urandom);
          cnt[d]++;
        end
      end else begin
        ack[d]  = ($urandom_range(0, 3) == 0);
        data[d] = 16'($urandom);
        tgt[d]  = -1;
      end
    end
  end

  // ALU: result presented LAT cycles after the operands it was computed from.
  logic [7:0] hist [2][4];
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int j = 3; j > 0; j--) hist[d][j] = hist[d][j-1];
      hist[d][0] = alu_f(op[d], in1[d], in2[d]);
      aout[d] = hist[d][lat_of(d)];
    end
  end

  int obs_addr [$], obs_a [$], obs_b [$], obs_op [$], obs_in1 [$], obs_in2 [$];
  int obs_hi [$], obs_gap [$], obs_ret [$];
  logic [7:0] model_a [2];
  logic [7:0] model_b [2];

  task automatic run_prog(input int d, input int max_fetch);
    int cyc = 0, hi = 0, lo = 0, held = 0;
    bit prev = 1'b0;
    obs_addr.delete(); obs_a.delete(); obs_b.delete(); obs_op.delete();
    obs_in1.delete(); obs_in2.delete(); obs_hi.delete(); obs_gap.delete();
    obs_ret.delete(); wait_q.delete();
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    forever begin
      if (req[d]) begin
        if (!prev) begin
          if (obs_addr.size() > 0) obs_gap.push_back(lo);
          obs_addr.push_back(addr_i[d]);
          obs_a.push_back(int'(acca[d]));
          obs_b.push_back(int'(accb[d]));
          obs_op.push_back(int'(op[d]));
          obs_in1.push_back(int'(in1[d]));
          obs_in2.push_back(int'(in2[d]));
`ifdef ALU_SEQ_RETIRE_CNT_EN
          obs_ret.push_back(int'(ret[d]));
`endif
          held = addr_i[d];
          hi = 0;
          if (obs_addr.size() > max_fetch) break;
        end else begin
          check($sformatf("d%0d_addr_hold", d), addr_i[d], held);
        end
        hi++;
      end else if (prev) begin
        obs_hi.push_back(hi);
        lo = 0;
      end
      if (!req[d]) lo++;
      if (halted[d]) break;
      cyc++;
      if (cyc > 3000) begin
        check($sformatf("d%0d_timeout", d), 1, 0);
        break;
      end
      prev = req[d];
      // Stray start pulses while busy must be ignored.
      start[d] = busy[d] && ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    start[d] = 1'b0;
  endtask

  task automatic compare_run(input int d, input int max_fetch);
    int pc = 0, n = 0;
    int mask = (d == 0) ? 255 : 3;
    logic [7:0] a, b, x, y;
    logic [15:0] w;
    bit halt = 1'b0;
    int e_addr [$], e_a [$], e_b [$], e_op [$], e_in1 [$], e_in2 [$];
    a = model_a[d];
    b = model_b[d];
    for (int k = 0; k <= max_fetch; k++) begin
      e_addr.push_back(pc); e_a.push_back(int'(a)); e_b.push_back(int'(b));
      if (k == max_fetch) break;
      w = mem[d][pc];
      pc = (pc + 1) & mask;
      if (w[15:10] == HALT_OP) begin
        halt = 1'b1;
        break;
      end
      x = w[9] ? b : a;
      y = w[8] ? w[7:0] : (w[9] ? a : b);
      e_op.push_back(int'(w[15:10])); e_in1.push_back(int'(x)); e_in2.push_back(int'(y));
      if (w[9]) b = alu_f(w[15:10], x, y);
      else a = alu_f(w[15:10], x, y);
      n++;
    end
    check($sformatf("d%0d_nfetch", d), obs_addr.size(), e_addr.size());
    for (int k = 0; k < obs_addr.size() && k < e_addr.size(); k++) begin
      check($sformatf("d%0d_addr[%0d]", d, k), obs_addr[k], e_addr[k]);
      check($sformatf("d%0d_acc_a[%0d]", d, k), obs_a[k], e_a[k]);
      check($sformatf("d%0d_acc_b[%0d]", d, k), obs_b[k], e_b[k]);
      if (k > 0) begin
        check($sformatf("d%0d_op[%0d]", d, k), obs_op[k], e_op[k-1]);
        check($sformatf("d%0d_in1[%0d]", d, k), obs_in1[k], e_in1[k-1]);
        check($sformatf("d%0d_in2[%0d]", d, k), obs_in2[k], e_in2[k-1]);
        check($sformatf("d%0d_gap[%0d]", d, k), obs_gap[k-1], lat_of(d) + 2);
      end
`ifdef ALU_SEQ_RETIRE_CNT_EN
      check($sformatf("d%0d_retired[%0d]", d, k), obs_ret[k], k);
`endif
    end
    for (int k = 0; k < obs_hi.size(); k++) begin
      if (k < wait_q.size()) check($sformatf("d%0d_req_len[%0d]", d, k), obs_hi[k], wait_q[k] + 1);
      else check($sformatf("d%0d_req_no_ack[%0d]", d, k), 1, 0);
    end
    if (halt) begin
      check($sformatf("d%0d_halted", d), halted[d], 1);
      check($sformatf("d%0d_busy_halt", d), busy[d], 0);
      check($sformatf("d%0d_req_halt", d), req[d], 0);
      check($sformatf("d%0d_final_a", d), acca[d], a);
      check($sformatf("d%0d_final_b", d), accb[d], b);
      check($sformatf("d%0d_final_pc", d), addr_i[d], pc);
`ifdef ALU_SEQ_RETIRE_CNT_EN
      check($sformatf("d%0d_final_retired", d), ret[d], n);
`endif
      model_a[d] = a;
      model_b[d] = b;
    end
  endtask

  task automatic chk_zero(input int d, input string t);
    check($sformatf("%s_d%0d_req", t, d), req[d], 0);
    check($sformatf("%s_d%0d_addr", t, d), addr_i[d], 0);
    check($sformatf("%s_d%0d_op", t, d), op[d], 0);
    check($sformatf("%s_d%0d_in1", t, d), in1[d], 0);
    check($sformatf("%s_d%0d_in2", t, d), in2[d], 0);
    check($sformatf("%s_d%0d_acc_a", t, d), acca[d], 0);
    check($sformatf("%s_d%0d_acc_b", t, d), accb[d], 0);
    check($sformatf("%s_d%0d_busy", t, d), busy[d], 0);
    check($sformatf("%s_d%0d_halted", t, d), halted[d], 0);
`ifdef ALU_SEQ_RETIRE_CNT_EN
    check($sformatf("%s_d%0d_retired", t, d), ret[d], 0);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      model_a[d] = '0;
      model_b[d] = '0;
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; ack[d] = 1'b0; data[d] = '0; aout[d] = '0;
      tgt[d] = -1; cnt[d] = 0; fixed_wait[d] = 0;
      model_a[d] = '0; model_b[d] = '0;
      for (int j = 0; j < 4; j++) hist[d][j] = '0;
      for (int j = 0; j < 256; j++) mem[d][j] = {HALT_OP, 10'd0};
    end
    // Reset held together with start: reset wins.
    start[0] = 1'b1;
    start[1] = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero(0, "rst");
    chk_zero(1, "rst");
    start[0] = 1'b0;
    start[1] = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    // Two immediate adds then halt, zero-wait memory.
    mem[0][0] = ins(OP_ADD, 1'b0, 1'b1, 8'd21);
    mem[0][1] = ins(OP_ADD, 1'b0, 1'b1, 8'd5);
    mem[0][2] = {HALT_OP, 10'h155};
    fixed_wait[0] = 0;
    run_prog(0, 1000);
    compare_run(0, 1000);
    check("p1_acc_a_after_first", obs_a.size() > 1 ? obs_a[1] : -1, 21);
    check("p1_acc_a", acca[0], 26);
    check("p1_acc_b", accb[0], 0);
    check("p1_req_period", (obs_hi.size() > 0 && obs_gap.size() > 0) ? obs_hi[0] + obs_gap[0] : -1, 4);

    // Same program with a 3-cycle ack delay.
    do_reset();
    fixed_wait[0] = 3;
    run_prog(0, 1000);
    compare_run(0, 1000);
    check("p2_req_len", obs_hi.size() > 0 ? obs_hi[0] : -1, 4);

    // Register-register AND after immediate loads.
    do_reset();
    mem[0][0] = ins(OP_MOV, 1'b0, 1'b1, 8'd13);
    mem[0][1] = ins(OP_MOV, 1'b1, 1'b1, 8'd5);
    mem[0][2] = ins(OP_AND, 1'b0, 1'b0, 8'hA5);
    mem[0][3] = {HALT_OP, 10'h3FF};
    fixed_wait[0] = -1;
    run_prog(0, 1000);
    compare_run(0, 1000);
    check("rr_in1", obs_in1.size() > 3 ? obs_in1[3] : -1, 13);
    check("rr_in2", obs_in2.size() > 3 ? obs_in2[3] : -1, 5);
    check("rr_acc_a", acca[0], 5);
    check("rr_acc_b", accb[0], 5);

    // Reset during EXEC, then rerun from address 0.
    do_reset();
    fixed_wait[0] = 0;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!req[0]) break;
      @(negedge clk);
    end
    check("exec_reach_decode", req[0], 0);
    @(negedge clk);
    check("exec_busy", busy[0], 1);
    reset = 1'b1;
    @(negedge clk);
    chk_zero(0, "exec_rst");
    reset = 1'b0;
    model_a[0] = '0;
    model_b[0] = '0;
    run_prog(0, 1000);
    compare_run(0, 1000);

    // Reset while an ack is being presented: request drops, the ack is ignored.
    do_reset();
    fixed_wait[0] = 3;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (ack[0]) break;
    end
    check("fetch_ack_seen", ack[0], 1);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk_zero(0, "fetch_rst");
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("idle_after_rst[%0d]", i), busy[0], 0);
    end
    model_a[0] = '0;
    model_b[0] = '0;

    // PC wrap on the AW=2 instance: fifth fetch returns to address 0.
    do_reset();
    mem[1][0] = ins(OP_ADD, 1'b0, 1'b1, 8'd1);
    mem[1][1] = ins(OP_ADD, 1'b1, 1'b1, 8'd2);
    mem[1][2] = ins(OP_XOR, 1'b0, 1'b0, 8'd0);
    mem[1][3] = ins(OP_SUB, 1'b1, 1'b1, 8'd3);
    fixed_wait[1] = -1;
    run_prog(1, 4);
    compare_run(1, 4);
    check("wrap_fifth_addr", obs_addr.size() > 4 ? obs_addr[4] : -1, 0);
`ifdef ALU_SEQ_RETIRE_CNT_EN
    check("wrap_retired", obs_ret.size() > 4 ? obs_ret[4] : -1, 4);
`endif
    do_reset();

    // Random programs on both instances, restarting from HALT or after reset.
    for (int it = 0; it < 30; it++) begin
      int d;
      d = int'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) do_reset();
      len = (d == 0) ? int'($urandom_range(0, 10)) : int'($urandom_range(0, 3));
      for (int i = 0; i < len; i++) begin
        mem[d][i] = rand_ins();
        while (mem[d][i][15:10] == HALT_OP) mem[d][i] = rand_ins();
      end
      mem[d][len] = {HALT_OP, 10'($urandom)};
      fixed_wait[d] = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 3));
      @(negedge clk);
      run_prog(d, 1000);
      compare_run(d, 1000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
